// File: rtl/ring_package.sv
// Shared ring network types: packet layout, commands and node helpers.
// Used by the node, the outbound queue and the cache-side adapters.
package ring_package;

    localparam int RING_NODES = 8;
    localparam int NODE_W     = $clog2(RING_NODES);

    typedef enum logic [2:0] {
        CMD_READ  = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_INV   = 3'd2,
        CMD_ACK   = 3'd3,
        CMD_DATA  = 3'd4
    } ring_cmd_t;

    typedef struct packed {
        logic              valid;
        logic              broadcast;
        ring_cmd_t         cmd;
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
        logic [15:0]       addr;
        logic [15:0]       data;
    } ring_packet_t;

    localparam int RING_PKT_W = $bits(ring_packet_t);

    // A unicast aimed at its own injector would circle the ring forever.
    function automatic logic ring_self_addressed(ring_packet_t pkt, int node);
        return !pkt.broadcast && (pkt.dest == NODE_W'(node));
    endfunction

endpackage

// File: rtl/ring_outbound_queue_fifo.sv
// Generic synchronous FIFO with a registered, non-show-ahead read port.
// Writes while full and reads while empty are ignored.
module ring_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_outbound_queue.sv
// Per-node injection queue: stamps the source ID, drops self-addressed
// unicasts and flags starvation when the ring never grants a slot.
module ring_outbound_queue
    import ring_package::*;
#(
    parameter int NODE_ID      = 0,
    parameter int DEPTH        = 8,
    parameter int AFULL_LEVEL  = 6,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [RING_PKT_W-1:0]    enq_packet,
    input  logic                     rdreq,
    output logic [RING_PKT_W-1:0]    q,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     self_drop,
    output logic                     starve
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    ring_packet_t  in_pkt;
    ring_packet_t  stamped;
    logic          fire;
    logic          drop;
    logic          store;
    logic          pop;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    assign in_pkt    = ring_packet_t'(enq_packet);
    assign enq_ready = !full;
    assign fire      = enq_valid && enq_ready;
    assign drop      = fire && ring_self_addressed(in_pkt, NODE_ID);
    assign store     = fire && !drop;
    assign pop       = rdreq && !empty;

    always_comb begin
        stamped       = in_pkt;
        stamped.valid = 1'b1;
        stamped.src   = NODE_W'(NODE_ID);
    end

    ring_sync_fifo #(
        .WIDTH (RING_PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (store),
        .wr_data (stamped),
        .rd_en   (rdreq),
        .rd_data (q),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    assign almost_full = (count >= (AW+1)'(AFULL_LEVEL));

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || empty) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // starve is registered from the same next value so it tracks the counter exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
            self_drop  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            starve     <= (starve_nxt == STARVE_MAX);
            self_drop  <= drop;
        end
    end

endmodule
